uart_tx_unit: RTL and testbench

Transmit half of the UART link. It pairs with the existing receive path and uses the same baud, oversampling and FIFO parameter set. The block contains three parts: a baud tick generator, a small TX FIFO that buffers bytes written by the host logic, and a transmitter FSM. The FSM drains the FIFO and serialises each byte onto tx as 8N1 frames: one start bit, DBIT data bits sent LSB first, and a stop period of SB_TICK ticks.

---
 rtl/uart_tx_unit.sv | 192 +++++++++++++++++++
 tb/tb_uart_tx_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_unit.sv
// uart_tx_unit: transmit half of the UART link.
//   A baud tick generator, a small TX FIFO and an 8N1 transmitter FSM.
//   The FSM drains the FIFO and sends each byte as: start bit, DBIT data
//   bits LSB first, then a stop period of SB_TICK oversample ticks.
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   wr_uart      write strobe, pushes w_data when tx_full is low
//   w_data[7:0]  byte to transmit
//   tx_full      TX FIFO full (registered)
//   tx           serial line, registered, idle high
//   tx_busy      frame in progress
//   tx_done_tick one-cycle pulse at the end of each stop period
module uart_tx_unit #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int DVSR       = 326,
  parameter int DVSR_WIDTH = 9,
  parameter int FIFO_W     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_uart,
  input  logic [7:0] w_data,
  output logic       tx_full,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done_tick
);

  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW = $clog2(DBIT);

  localparam logic [DVSR_WIDTH-1:0] DV_LAST = DVSR_WIDTH'(DVSR - 1);
  localparam logic [DVSR_WIDTH-1:0] DV_ONE  = DVSR_WIDTH'(1);
  localparam logic [SW-1:0]         S_BIT   = SW'(15);
  localparam logic [SW-1:0]         S_STOP  = SW'(SB_TICK - 1);
  localparam logic [SW-1:0]         S_ONE   = SW'(1);
  localparam logic [NW-1:0]         N_LAST  = NW'(DBIT - 1);
  localparam logic [NW-1:0]         N_ONE   = NW'(1);
  localparam logic [FIFO_W-1:0]     P_ONE   = FIFO_W'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  typedef struct packed {
    state_t         st;
    logic [SW-1:0]  s;   // oversample tick count within the current bit
    logic [NW-1:0]  n;   // data bit index
    logic [7:0]     b;   // shift register, LSB goes out first
  } fsm_t;

  fsm_t cur, nxt;
  logic tx_nx, done_nx, pop;

  // ---------------- baud tick generator ----------------
  // Held at zero while idle so every frame starts on a fresh bit boundary.
  logic [DVSR_WIDTH-1:0] cnt;
  logic                  s_tick;

  always_ff @(posedge clk) begin
    if (!rst_n)                          cnt <= '0;
    else if (cur.st == IDLE || s_tick)   cnt <= '0;
    else                                 cnt <= cnt + DV_ONE;
  end

  assign s_tick = (cnt == DV_LAST);

  // ---------------- TX FIFO ----------------
  logic [7:0]        mem [2**FIFO_W];
  logic [FIFO_W-1:0] wp, rp;
  logic              full, empty;
  logic              wr_en, rd_en;
  logic [7:0]        head;

  assign wr_en = wr_uart & ~full;
  assign rd_en = pop & ~empty;
  assign head  = mem[rp];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wp] <= w_data;
  end

  // Flags are registered; a simultaneous push and pop leaves them unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      case ({wr_en, rd_en})
        2'b10: begin
          wp    <= wp + P_ONE;
          empty <= 1'b0;
          full  <= ((wp + P_ONE) == rp);
        end
        2'b01: begin
          rp    <= rp + P_ONE;
          full  <= 1'b0;
          empty <= ((rp + P_ONE) == wp);
        end
        2'b11: begin
          wp <= wp + P_ONE;
          rp <= rp + P_ONE;
        end
        default: ;
      endcase
    end
  end

  // ---------------- transmitter FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) cur <= '{st: IDLE, s: '0, n: '0, b: '0};
    else        cur <= nxt;
  end

  always_comb begin
    nxt     = cur;
    pop     = 1'b0;
    done_nx = 1'b0;
    tx_nx   = 1'b1;
    case (cur.st)
      IDLE: begin
        if (!empty) begin
          nxt.b  = head;
          nxt.s  = '0;
          nxt.st = START;
          pop    = 1'b1;
        end
      end
      START: begin
        tx_nx = 1'b0;
        if (s_tick) begin
          if (cur.s == S_BIT) begin
            nxt.s  = '0;
            nxt.n  = '0;
            nxt.st = DATA;
          end else begin
            nxt.s = cur.s + S_ONE;
          end
        end
      end
      DATA: begin
        tx_nx = cur.b[0];
        if (s_tick) begin
          if (cur.s == S_BIT) begin
            nxt.s = '0;
            nxt.b = cur.b >> 1;
            if (cur.n == N_LAST) nxt.st = STOP;
            else                 nxt.n  = cur.n + N_ONE;
          end else begin
            nxt.s = cur.s + S_ONE;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (cur.s == S_STOP) begin
            done_nx = 1'b1;
            nxt.st  = IDLE;
          end else begin
            nxt.s = cur.s + S_ONE;
          end
        end
      end
      default: nxt.st = IDLE;
    endcase
  end

  // Output registers. tx, tx_busy and tx_done_tick share one register
  // stage so they stay aligned on the line: busy rises with the start
  // bit and drops after the cycle carrying the done pulse.
  logic tx_r, busy_r, done_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_r   <= 1'b1;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      tx_r   <= tx_nx;
      busy_r <= (cur.st != IDLE);
      done_r <= done_nx;
    end
  end

  assign tx           = tx_r;
  assign tx_busy      = busy_r;
  assign tx_done_tick = done_r;
  assign tx_full      = full;

endmodule

// File: tb/tb_uart_tx_unit.sv
// tb_uart_tx_unit: directed + randomized bench for uart_tx_unit.
//   A behavioural line decoder samples tx at bit centres and rebuilds
//   bytes, which are compared with the queue of bytes that were written.
module tb_uart_tx_unit;

  localparam int DV   = 4;
  localparam int BITC = 16 * DV;
  localparam int L16  = 9 * BITC + 16 * DV;
  localparam int L32  = 9 * BITC + 32 * DV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_uart = 1'b0;
  logic [7:0] w_data = 8'h00;
  logic       tx_full, tx, tx_busy, tx_done_tick;
  logic       wr32 = 1'b0;
  logic [7:0] d32 = 8'h00;
  logic       full32, tx32, busy32, done32;

  uart_tx_unit #(.DBIT(8), .SB_TICK(16), .DVSR(DV), .DVSR_WIDTH(9), .FIFO_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .wr_uart(wr_uart), .w_data(w_data),
    .tx_full(tx_full), .tx(tx), .tx_busy(tx_busy), .tx_done_tick(tx_done_tick));

  uart_tx_unit #(.DBIT(8), .SB_TICK(32), .DVSR(DV), .DVSR_WIDTH(9), .FIFO_W(2)) dut32 (
    .clk(clk), .rst_n(rst_n), .wr_uart(wr32), .w_data(d32),
    .tx_full(full32), .tx(tx32), .tx_busy(busy32), .tx_done_tick(done32));

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [7:0] rx_q[$];
  logic       ok_q[$];
  int         fall_q[$];
  int         done_q[$];
  logic [7:0] exp_q[$];
  logic [9:0] last_bits;

  // Line decoder: detects a falling edge from idle, samples the middle of
  // each of the 10 bit periods, aborts on reset.
  bit         m_act = 1'b0;
  int         m_cnt = 0;
  logic [9:0] m_bits;
  logic       tx_q1 = 1'b1;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_act = 1'b0;
    end else begin
      if (tx_done_tick === 1'b1) done_q.push_back(cyc);
      if (!m_act) begin
        if (tx_q1 === 1'b1 && tx === 1'b0) begin
          m_act = 1'b1;
          m_cnt = 0;
          fall_q.push_back(cyc);
        end
      end else begin
        m_cnt++;
        if (m_cnt % BITC == BITC / 2) begin
          m_bits[m_cnt / BITC] = tx;
          if (m_cnt / BITC == 9) begin
            rx_q.push_back(m_bits[8:1]);
            ok_q.push_back(m_bits[0] == 1'b0 && m_bits[9] == 1'b1);
            last_bits = m_bits;
            m_act = 1'b0;
          end
        end
      end
    end
    tx_q1 = tx;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    rx_q.delete();
    ok_q.delete();
    fall_q.delete();
    done_q.delete();
  endtask

  task automatic wait_rx(input int n, input int budget);
    int t = 0;
    while (rx_q.size() < n && t < budget) begin step(); t++; end
    chk("wait_rx", 32'(rx_q.size() >= n), 32'd1);
  endtask

  task automatic wait_fall(input int n, input int budget);
    int t = 0;
    while (fall_q.size() < n && t < budget) begin step(); t++; end
    chk("wait_fall", 32'(fall_q.size() >= n), 32'd1);
  endtask

  // Compares the decoded stream with exp_q: order, framing, frame length
  // and the one-cycle idle gap between back-to-back frames.
  task automatic check_stream(input string tag);
    chk({tag, "_cnt"}, rx_q.size(), exp_q.size());
    chk({tag, "_done_cnt"}, done_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      chk($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
      chk($sformatf("%s_frame%0d", tag, i), ok_q[i], 1);
      if (i < done_q.size())
        chk($sformatf("%s_len%0d", tag, i), done_q[i] - fall_q[i] + 1, L16);
      if (i > 0)
        chk($sformatf("%s_gap%0d", tag, i), fall_q[i] - fall_q[i-1], L16 + 1);
    end
  endtask

  initial begin
    int   k, f, r, d, t, n, target;
    logic allhigh;
    logic [7:0] b;

    // ---- reset ----
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("rst_tx", tx, 1);
    chk("rst_full", tx_full, 0);
    chk("rst_busy", tx_busy, 0);
    chk("rst_done", tx_done_tick, 0);
    chk("rst_tx32", tx32, 1);
    allhigh = 1'b1;
    repeat (1000) begin
      step();
      if (tx !== 1'b1) allhigh = 1'b0;
    end
    chk("idle_high", allhigh, 1);
    chk("idle_nofall", fall_q.size(), 0);

    // ---- single byte 0xA3 ----
    clr();
    wr_uart = 1'b1; w_data = 8'hA3;
    step();
    wr_uart = 1'b0;
    k = cyc;
    wait_rx(1, 2000);
    chk("a3_latency", fall_q[0] - k, 2);
    chk("a3_busy_stop", tx_busy, 1);
    b = 8'hA3;
    for (int i = 0; i < 10; i++)
      chk($sformatf("a3_bit%0d", i), last_bits[i],
          (i == 0) ? 0 : (i == 9) ? 1 : 32'((b >> (i - 1)) & 8'h01));
    chk("a3_byte", rx_q[0], 8'hA3);
    repeat (40) step();
    chk("a3_done_cnt", done_q.size(), 1);
    chk("a3_len", done_q[0] - fall_q[0] + 1, L16);
    chk("a3_busy_end", tx_busy, 0);

    // ---- fill and overflow ----
    clr();
    exp_q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) begin
      wr_uart = 1'b1; w_data = exp_q[i];
      step();
      if (i == 3) chk("fill_not_full4", tx_full, 0);
    end
    chk("fill_full5", tx_full, 1);
    w_data = 8'h66;
    step();
    wr_uart = 1'b0;
    chk("fill_full_drop", tx_full, 1);
    wait_rx(1, 2000);
    repeat (40) step();
    chk("fill_full_clr", tx_full, 0);
    wait_rx(5, 5000);
    repeat (800) step();
    check_stream("fill");

    // ---- reset mid-frame ----
    clr();
    wr_uart = 1'b1; w_data = 8'hFF; step();
    w_data = 8'h01; step();
    w_data = 8'h02; step();
    wr_uart = 1'b0;
    wait_fall(1, 100);
    target = fall_q[0] + BITC * 4 + BITC / 2;
    while (cyc < target) step();
    chk("mid_busy", tx_busy, 1);
    chk("mid_tx_data", tx, 1);
    rst_n = 1'b0;
    step();
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_busy", tx_busy, 0);
    chk("mid_rst_full", tx_full, 0);
    chk("mid_rst_done", tx_done_tick, 0);
    step();
    rst_n = 1'b1;
    repeat (1500) step();
    chk("mid_no_frames", fall_q.size(), 1);
    chk("mid_no_bytes", rx_q.size(), 0);
    chk("mid_no_done", done_q.size(), 0);
    chk("mid_idle_tx", tx, 1);

    // ---- two-bit stop period ----
    wr32 = 1'b1; d32 = 8'h00;
    step();
    wr32 = 1'b0;
    k = cyc;
    t = 0;
    while (tx32 !== 1'b0 && t < 100) begin step(); t++; end
    f = cyc;
    while (tx32 !== 1'b1 && t < 2000) begin step(); t++; end
    r = cyc;
    while (done32 !== 1'b1 && t < 3000) begin step(); t++; end
    d = cyc;
    chk("sb32_latency", f - k, 2);
    chk("sb32_low", r - f, 9 * BITC);
    chk("sb32_stop", d - r + 1, 32 * DV);
    chk("sb32_len", d - f + 1, L32);
    repeat (10) step();
    chk("sb32_busy_end", busy32, 0);

    // ---- randomized bursts ----
    for (int it = 0; it < 5; it++) begin
      clr();
      exp_q.delete();
      n = $urandom_range(1, 5);
      wr_uart = 1'b1;
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        w_data = b;
        step();
      end
      wr_uart = 1'b0;
      wait_rx(n, 800 * n + 100);
      repeat (60) step();
      check_stream($sformatf("rnd%0d", it));
    end

    // ---- loopback through the line decoder ----
    clr();
    exp_q = {8'h00, 8'hFF, 8'h5A, 8'hC3};
    wr_uart = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w_data = exp_q[i];
      step();
    end
    wr_uart = 1'b0;
    wait_rx(4, 4000);
    repeat (60) step();
    check_stream("loop");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
